// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
//   Shared definitions for the matrix-multiply operand loader:
//     - state_t and the loader state constants (FIRST, LOAD_A, LOAD_B, LOADED)
//     - a_depth / b_depth helpers that size the A (M x MAXK) and
//       B (MAXK x N) operand memories
// -----------------------------------------------------------------------------
package matrix_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_FIRST  = 2'd0;  // waiting for the first beat of a packet
  localparam state_t ST_LOAD_A = 2'd1;  // streaming matrix A, row-major
  localparam state_t ST_LOAD_B = 2'd2;  // streaming matrix B, row-major
  localparam state_t ST_LOADED = 2'd3;  // operands stable, owned by the consumer

  // Worst-case element count of A (M rows by up to MAXK columns).
  function automatic int a_depth(input int m, input int maxk);
    return m * maxk;
  endfunction

  // Worst-case element count of B (up to MAXK rows by N columns).
  function automatic int b_depth(input int maxk, input int n);
    return maxk * n;
  endfunction

endpackage

// File: rtl/loader_ram.sv
// -----------------------------------------------------------------------------
// loader_ram
//   Simple dual-port operand memory: one write port and one read port with a
//   registered output (one-cycle read latency).
//
//   Parameters: WIDTH (element width), DEPTH (number of elements)
//   Ports:
//     clk    in   clock, rising edge
//     reset  in   asynchronous active-low; clears only the read register
//     we     in   write enable
//     waddr  in   write address
//     wdata  in   write data
//     raddr  in   read address, sampled on the rising edge
//     rdata  out  registered read data
// -----------------------------------------------------------------------------
module loader_ram #(
  parameter  int WIDTH = 12,
  parameter  int DEPTH = 56,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array itself has no reset, so it can map onto block RAM; only
  // the output register is cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      // NOTE: non-blocking assignment for all clocked state.
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
//   Operand stage of the matrix-multiply pipeline. Receives matrix A (M x K)
//   followed by matrix B (K x N), both row-major, on an AXI-Stream. It holds
//   them for the compute controller until compute_finished is pulsed. A
//   packet whose first beat has new_A = 0 carries only B and reuses the
//   stored A. If no A is stored yet, such a packet is treated as new_A = 1.
//
//   Optional feature: define MATRIX_LOADER_KCHECK_EN to detect an illegal K
//   (0 or > MAXK) on a new-A first beat. The sticky k_err flag is then set
//   and K is latched as MAXK. Without the macro, K is latched verbatim and
//   k_err is tied to 0.
//
//   Ports:
//     clk               in   clock, rising edge
//     reset             in   asynchronous active-low reset
//     INPUT_TDATA       in   stream element (INW bits, signed)
//     INPUT_TVALID      in   element valid
//     INPUT_TUSER       in   {K, new_A}; sampled on the first beat only
//     INPUT_TREADY      out  high in every state except LOADED
//     matrices_loaded   out  A and B complete and stable
//     compute_finished  in   consumer releases the operands (LOADED only)
//     K                 out  inner dimension of the stored A
//     A_read_addr       in   A element index, row*K + col
//     A_data            out  A element, one-cycle latency
//     B_read_addr       in   B element index, row*N + col
//     B_data            out  B element, one-cycle latency
//     k_err             out  sticky illegal-K flag
// -----------------------------------------------------------------------------
module matrix_loader
  import matrix_pkg::*;
#(
  parameter  int INW     = 12,
  parameter  int M       = 7,
  parameter  int N       = 9,
  parameter  int MAXK    = 8,
  localparam int K_BITS  = $clog2(MAXK + 1),
  localparam int A_DEPTH = a_depth(M, MAXK),
  localparam int B_DEPTH = b_depth(MAXK, N),
  localparam int A_AW    = $clog2(A_DEPTH),
  localparam int B_AW    = $clog2(B_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [INW-1:0]    INPUT_TDATA,
  input  logic              INPUT_TVALID,
  input  logic [K_BITS:0]   INPUT_TUSER,
  output logic              INPUT_TREADY,
  output logic              matrices_loaded,
  input  logic              compute_finished,
  output logic [K_BITS-1:0] K,
  input  logic [A_AW-1:0]   A_read_addr,
  output logic [INW-1:0]    A_data,
  input  logic [B_AW-1:0]   B_read_addr,
  output logic [INW-1:0]    B_data,
  output logic              k_err
);

  // The beat counter is wide enough for the larger of the two element counts,
  // so the products M*K and K*N are never truncated.
  localparam int A_CW = $clog2(A_DEPTH + 1);
  localparam int B_CW = $clog2(B_DEPTH + 1);
  localparam int CW   = (A_CW > B_CW) ? A_CW : B_CW;

  localparam logic [CW-1:0]     M_C    = CW'(M);
  localparam logic [CW-1:0]     N_C    = CW'(N);
  localparam logic [CW-1:0]     ONE_C  = CW'(1);
  localparam logic [K_BITS-1:0] MAXK_K = K_BITS'(MAXK);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [K_BITS-1:0] k_q, k_d;
  logic              a_valid_q, a_valid_d;

  logic              xfer;
  logic [K_BITS-1:0] k_field;
  logic              new_a_field;
  logic              take_a;
  logic [K_BITS-1:0] k_first;
  logic [CW-1:0]     a_len_first;
  logic [CW-1:0]     a_len;
  logic [CW-1:0]     b_len;

  logic              a_we, b_we;
  logic [A_AW-1:0]   a_waddr;
  logic [B_AW-1:0]   b_waddr;

  assign INPUT_TREADY    = (state_q != ST_LOADED);
  assign matrices_loaded = (state_q == ST_LOADED);
  assign K               = k_q;

  assign xfer        = INPUT_TVALID && INPUT_TREADY;
  assign k_field     = INPUT_TUSER[K_BITS:1];
  assign new_a_field = INPUT_TUSER[0];
  // A B-only packet with no A stored yet still has to start by loading A.
  assign take_a      = new_a_field || !a_valid_q;

`ifdef MATRIX_LOADER_KCHECK_EN
  logic k_bad;
  logic k_err_q;

  assign k_bad   = (k_field == '0) || (k_field > MAXK_K);
  assign k_first = k_bad ? MAXK_K : k_field;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k_err_q <= 1'b0;
    end else if ((state_q == ST_FIRST) && xfer && take_a && k_bad) begin
      k_err_q <= 1'b1;
    end
  end

  assign k_err = k_err_q;
`else
  assign k_first = k_field;
  assign k_err   = 1'b0;
`endif

  // A length for the packet being started uses the K arriving on this beat;
  // every other length uses the latched K.
  assign a_len_first = M_C * CW'(k_first);
  assign a_len       = M_C * CW'(k_q);
  assign b_len       = CW'(k_q) * N_C;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    k_d       = k_q;
    a_valid_d = a_valid_q;
    a_we      = 1'b0;
    b_we      = 1'b0;
    a_waddr   = A_AW'(cnt_q);
    b_waddr   = B_AW'(cnt_q);

    case (state_q)
      ST_FIRST: begin
        if (xfer) begin
          if (take_a) begin
            k_d     = k_first;
            a_we    = 1'b1;
            a_waddr = '0;
            if (a_len_first == ONE_C) begin
              state_d   = ST_LOAD_B;
              cnt_d     = '0;
              a_valid_d = 1'b1;
            end else begin
              state_d = ST_LOAD_A;
              cnt_d   = ONE_C;
            end
          end else begin
            b_we    = 1'b1;
            b_waddr = '0;
            if (b_len == ONE_C) begin
              state_d = ST_LOADED;
              cnt_d   = '0;
            end else begin
              state_d = ST_LOAD_B;
              cnt_d   = ONE_C;
            end
          end
        end
      end

      ST_LOAD_A: begin
        if (xfer) begin
          a_we = 1'b1;
          if (cnt_q == a_len - ONE_C) begin
            state_d   = ST_LOAD_B;
            cnt_d     = '0;
            a_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end

      ST_LOAD_B: begin
        if (xfer) begin
          b_we = 1'b1;
          if (cnt_q == b_len - ONE_C) begin
            state_d = ST_LOADED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
          end
        end
      end

      ST_LOADED: begin
        if (compute_finished) begin
          state_d = ST_FIRST;
        end
      end

      default: begin
        state_d = ST_FIRST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FIRST;
      cnt_q     <= '0;
      k_q       <= '0;
      a_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      k_q       <= k_d;
      a_valid_q <= a_valid_d;
    end
  end

  loader_ram #(
    .WIDTH (INW),
    .DEPTH (A_DEPTH)
  ) u_a_ram (
    .clk   (clk),
    .reset (reset),
    .we    (a_we),
    .waddr (a_waddr),
    .wdata (INPUT_TDATA),
    .raddr (A_read_addr),
    .rdata (A_data)
  );

  loader_ram #(
    .WIDTH (INW),
    .DEPTH (B_DEPTH)
  ) u_b_ram (
    .clk   (clk),
    .reset (reset),
    .we    (b_we),
    .waddr (b_waddr),
    .wdata (INPUT_TDATA),
    .raddr (B_read_addr),
    .rdata (B_data)
  );

endmodule
